// File: rtl/neuron_pkg.sv
// Shared fixed-point types and detector state encoding for the neuron core.
package neuron_pkg;

  localparam int INT_W = 3;
  localparam int FRC_W = 12;
  localparam int W     = 1 + INT_W + FRC_W;

  typedef logic signed [W-1:0] q3_12_t;

  typedef enum logic [1:0] {
    ARMED,
    REFRACT,
    WAIT_REARM
  } det_state_t;

  localparam q3_12_t Q_ONE = q3_12_t'(1 << FRC_W);

endpackage

// File: rtl/spike_fifo.sv
// Small synchronous fall-through FIFO for spike timestamps; a pop frees a slot
// for a push in the same cycle even when full.
module spike_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: empty gates the output until a slot is written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_in;
  end

endmodule

// File: rtl/spike_detector.sv
// Threshold-crossing spike detector with refractory window, re-arm hysteresis
// and a timestamped event FIFO.
module spike_detector #(
  parameter int                    W       = 16,
  parameter logic signed [W-1:0]   V_TH    = 16'sd2048,
  parameter logic signed [W-1:0]   V_REARM = -16'sd1024,
  parameter int                    REFRACT = 32,
  parameter int                    TS_W    = 16,
  parameter int                    DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] v_in,
  input  logic                v_valid,
  output logic                spike,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [TS_W-1:0]     evt_ts,
  output logic                overflow,
  output logic                armed
);

  import neuron_pkg::*;

  localparam int RC_W = $clog2(REFRACT + 1);

  det_state_t          state, state_n;
  logic [RC_W-1:0]     rcnt, rcnt_n;
  logic [TS_W-1:0]     ts;
  logic signed [W-1:0] v_prev;
  logic                prev_vld;
  logic                crossing;
  logic                fire;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;

  assign crossing  = prev_vld && (v_prev < V_TH) && (v_in >= V_TH);
  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready;
  assign armed     = (state == ARMED);

  // The REFRACT parameter shadows the imported state name, hence the scoped reference.
  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    fire    = 1'b0;
    if (v_valid) begin
      unique case (state)
        ARMED: begin
          if (crossing) begin
            fire    = 1'b1;
            state_n = neuron_pkg::REFRACT;
            rcnt_n  = RC_W'(REFRACT - 1);
          end
        end
        neuron_pkg::REFRACT: begin
          if (rcnt != '0)
            rcnt_n = rcnt - 1'b1;
          else if (v_in < V_REARM)
            state_n = ARMED;
          else
            state_n = WAIT_REARM;
        end
        WAIT_REARM: begin
          if (v_in < V_REARM) state_n = ARMED;
        end
        default: state_n = ARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARMED;
      rcnt     <= '0;
      ts       <= '0;
      v_prev   <= '0;
      prev_vld <= 1'b0;
      spike    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      rcnt  <= rcnt_n;
      spike <= fire;
      if (fire && fifo_full && !pop) overflow <= 1'b1;
      if (v_valid) begin
        ts       <= ts + 1'b1;
        v_prev   <= v_in;
        prev_vld <= 1'b1;
      end
    end
  end

  spike_fifo #(
    .DATA_W (TS_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fire),
    .data_in  (ts),
    .full     (fifo_full),
    .pop      (pop),
    .data_out (evt_ts),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_spike_detector.sv
// Bench for spike_detector: index-based reference model with a per-cycle compare,
// directed scenarios pinned by literal expectations, and a randomized wave.
module tb_spike_detector;

  localparam int V_TH    = 2048;
  localparam int V_REARM = -1024;
  localparam int REFRACT = 32;
  localparam int DEPTH   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] v_in = '0;
  logic               v_valid = 1'b0;
  logic               evt_ready = 1'b0;
  logic               spike;
  logic               evt_valid;
  logic [15:0]        evt_ts;
  logic               overflow;
  logic               armed;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // reference model state
  logic [15:0] mq[$];
  int  idx, last_idx, m_prev, m_spikes;
  bit  have_prev, spiked, rearmed, m_spike, m_ovf, m_armed;

  // observations of the DUT
  int          dut_spikes;
  logic [15:0] popped[$];

  spike_detector dut (
    .clk       (clk),
    .rst       (rst),
    .v_in      (v_in),
    .v_valid   (v_valid),
    .spike     (spike),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ts    (evt_ts),
    .overflow  (overflow),
    .armed     (armed)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic vv, input int v, input logic rdy);
    rst       = r;
    v_valid   = vv;
    v_in      = 16'(v);
    evt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // One -2000 sample, then n spikes each followed by a full refractory window held low.
  task automatic fireTrain(input int n, input logic rdy);
    applyStimulus(1'b0, 1'b1, -2000, rdy);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 1'b1, 3000, rdy);
      for (int j = 0; j < REFRACT; j++) applyStimulus(1'b0, 1'b1, -2000, rdy);
    end
  endtask

  // Behavioural model: spikes counted by sample index; re-arm allowed once REFRACT
  // samples after the spike and a sample below V_REARM has been seen.
  always @(posedge clk) begin
    bit   pop, fire;
    int   vi;
    logic [15:0] stamp;
    if (rst) begin
      mq.delete();
      idx = 0; last_idx = 0; m_prev = 0; m_spikes = 0;
      have_prev = 0; spiked = 0; rearmed = 0;
      m_spike = 0; m_ovf = 0; m_armed = 1;
    end else begin
      pop   = (mq.size() > 0) && evt_ready;
      fire  = 0;
      stamp = '0;
      if (v_valid) begin
        vi = int'(v_in);
        if (have_prev && m_prev < V_TH && vi >= V_TH && (!spiked || rearmed)) begin
          fire = 1; last_idx = idx; spiked = 1; rearmed = 0;
        end else if (spiked && !rearmed && idx >= last_idx + REFRACT && vi < V_REARM) begin
          rearmed = 1;
        end
        m_prev = vi; have_prev = 1;
        stamp = idx[15:0];
        idx++;
      end
      if (pop) void'(mq.pop_front());
      if (fire) begin
        m_spikes++;
        if (mq.size() < DEPTH) mq.push_back(stamp);
        else m_ovf = 1;
      end
      m_spike = fire;
      m_armed = !spiked || rearmed;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("spike", {31'd0, spike}, {31'd0, m_spike});
      checkOutput("armed", {31'd0, armed}, {31'd0, m_armed});
      checkOutput("overflow", {31'd0, overflow}, {31'd0, m_ovf});
      checkOutput("evt_valid", {31'd0, evt_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) checkOutput("evt_ts", {16'd0, evt_ts}, {16'd0, mq[0]});
      if (spike) dut_spikes++;
      if (evt_valid && evt_ready) popped.push_back(evt_ts);
    end
  end

  task automatic checkPopped(input string name, input int exp_ts[$]);
    checkOutput({name, "_count"}, popped.size(), exp_ts.size());
    for (int i = 0; i < exp_ts.size() && i < popped.size(); i++)
      checkOutput({name, "_ts"}, {16'd0, popped[i]}, exp_ts[i]);
  endtask

  task automatic startTest();
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    dut_spikes = 0;
    popped.delete();
  endtask

  initial begin
    int base[10] = '{-3000, -1800, -600, 600, 1800, 3000, 1800, 600, -600, -1800};
    int v;

    // reset state
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    chk_en = 1'b1;
    checkOutput("rst_spike", {31'd0, spike}, 0);
    checkOutput("rst_evt_valid", {31'd0, evt_valid}, 0);
    checkOutput("rst_evt_ts", {16'd0, evt_ts}, 0);
    checkOutput("rst_overflow", {31'd0, overflow}, 0);
    checkOutput("rst_armed", {31'd0, armed}, 1);
    dut_spikes = 0;
    popped.delete();

    // ramp -4096 -> +4096: single spike at v=2048, timestamp 12
    for (int k = 0; k <= 16; k++) applyStimulus(1'b0, 1'b1, -4096 + 512 * k, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkOutput("ramp_spikes", dut_spikes, 1);
    checkPopped("ramp", '{12});

    // hold above threshold: never re-arms, never fires again
    for (int k = 0; k < 100; k++) applyStimulus(1'b0, 1'b1, 3000, 1'b1);
    checkOutput("hold_spikes", dut_spikes, 1);
    checkOutput("hold_armed", {31'd0, armed}, 0);

    // randomized sinusoid-like wave with gaps and back-pressure
    startTest();
    for (int k = 0; k < 500; k++) begin
      v = base[k % 10] + int'($urandom_range(0, 200)) - 100;
      applyStimulus(1'b0, $urandom_range(0, 3) != 0, v, $urandom_range(0, 2) != 0);
    end
    checkOutput("wave_spikes", dut_spikes, m_spikes);

    // 6 spikes into a blocked FIFO: first 4 kept, overflow sticky
    startTest();
    fireTrain(6, 1'b0);
    checkOutput("ovf_set", {31'd0, overflow}, 1);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkPopped("ovf_drain", '{1, 34, 67, 100});
    checkOutput("ovf_sticky", {31'd0, overflow}, 1);

    // full FIFO with simultaneous push and pop
    startTest();
    fireTrain(4, 1'b0);
    applyStimulus(1'b0, 1'b1, 3000, 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("pp_no_ovf", {31'd0, overflow}, 0);
    checkOutput("pp_popped_one", popped.size(), 1);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 0, 1'b1);
    checkPopped("pp_drain", '{1, 34, 67, 100, 133});

    // reset mid-refractory with two queued events
    startTest();
    fireTrain(1, 1'b0);
    applyStimulus(1'b0, 1'b1, 3000, 1'b0);
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, -2000, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    checkOutput("mid_rst_spike", {31'd0, spike}, 0);
    checkOutput("mid_rst_evt_valid", {31'd0, evt_valid}, 0);
    checkOutput("mid_rst_evt_ts", {16'd0, evt_ts}, 0);
    checkOutput("mid_rst_overflow", {31'd0, overflow}, 0);
    checkOutput("mid_rst_armed", {31'd0, armed}, 1);
    applyStimulus(1'b0, 1'b1, -2000, 1'b0);
    applyStimulus(1'b0, 1'b1, 3000, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);
    checkOutput("ts_restart_valid", {31'd0, evt_valid}, 1);
    checkOutput("ts_restart_ts", {16'd0, evt_ts}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_detector.md
# spike_detector

Downstream stage of the neuron core: samples the membrane potential `v` (signed Q3.12, 16 bit) each update, detects upward threshold crossings, enforces a refractory window and a re-arm hysteresis, and emits each spike as a timestamped event through a small FIFO with a valid/ready handshake. It turns the core's continuous state trajectory into the discrete spike stream consumed by the routing/readout logic.

## Interface

- Clocking: one clock; reset is synchronous and active-high.
- `W`, 16: sample width, signed Q3.12 (1 sign, 3 integer, 12 fraction bits).
- `V_TH`, 16'sd2048 (+0.5): spike threshold.
- `V_REARM`, -16'sd1024 (-0.25): re-arm level; must satisfy V_REARM < V_TH.
- `REFRACT`, 32: refractory length in accepted samples, ≥1.
- `TS_W`, 16: timestamp width.
- `DEPTH`, 4: event FIFO depth, power of two, ≥2.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `v_in`  in  W  signed membrane potential from the core.
- `v_valid`  in  1  `v_in` is a new sample this cycle.
- `spike`  out  1  one-cycle pulse per detected spike.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head event.
- `evt_ts`  out  TS_W  timestamp of the head event.
- `overflow`  out  1  sticky: a spike was dropped because the FIFO was full.
- `armed`  out  1  FSM is in ARMED.

## Operation

- All state advances only on cycles with `v_valid`=1, except FIFO pop.
- Timestamp counter `ts`: increments by 1 per accepted sample and wraps modulo 2^TS_W. A sample is stamped with the `ts` value before its increment, so the first sample after reset has timestamp 0.
- `v_prev`: the last accepted sample. `prev_vld` is cleared by reset and set by the first sample. A crossing requires `prev_vld`=1, so the first sample after reset never fires.
- Crossing: `prev_vld` && `v_prev` < V_TH && `v_in` ≥ V_TH. All comparisons are signed.
- FSM states:
  - ARMED: on a crossing, fire and go to REFRACT with `rcnt` = REFRACT-1.
  - REFRACT: each sample with `rcnt`≠0 decrements `rcnt`. A sample with `rcnt`=0 goes to WAIT_REARM, or directly to ARMED if that same `v_in` < V_REARM. Crossings are ignored.
  - WAIT_REARM: a sample with `v_in` < V_REARM goes to ARMED. The re-arming sample cannot itself fire.
- Fire: `spike` pulses, and {ts} is pushed to the FIFO.
  - If the FIFO is full and no pop happens that cycle, the event is dropped and `overflow` is set.
  - `overflow` is cleared only by `rst`.
- FIFO: pop when `evt_valid` && `evt_ready`.
  - Push and pop in the same cycle are both honoured, including when full; occupancy is then unchanged.
  - `evt_ts` holds steady while `evt_valid`=1 and `evt_ready`=0.
- Reset values:
  - outputs: `spike`=0, `evt_valid`=0, `evt_ts`=0, `overflow`=0, `armed`=1.
  - internal: FSM=ARMED, `ts`=0, `rcnt`=0, `prev_vld`=0, `v_prev`=0, FIFO empty.
- Reset asserted mid-refractory or with a non-empty FIFO discards all state, including queued events.

## Timing

- Sample accepted at edge N. `spike` is high during cycle N+1, for exactly one cycle.
- An event pushed at edge N into an empty FIFO shows `evt_valid`=1 and `evt_ts` valid in cycle N+1; fall-through latency is 1.
- Pop at edge M: the next entry, if any, is visible in cycle M+1. Sustained throughput is 1 event/cycle.
- Minimum spacing between spikes is REFRACT+1 accepted samples.
- `armed` reflects the registered FSM state.

## Structure

- Shared package `neuron_pkg`:
  - fixed-point constants `INT_W`=3, `FRC_W`=12, `W`=16.
  - typedef `q3_12_t` (signed [15:0]).
  - enum `det_state_t` {ARMED, REFRACT, WAIT_REARM}.
  - a `Q_ONE` constant.
- One sub-module `spike_fifo`: synchronous FIFO, parameters DATA_W and DEPTH.
  - Ports: push/data_in/full, pop/data_out/empty.
  - Pointers are log2(DEPTH)+1 bits wide.
- The FSM, crossing compare, refractory counter and timestamp live in `spike_detector`.

## Test plan

- Reset, then ramp `v_in` -4096→+4096 in steps of 512, one sample per cycle, `evt_ready`=1. Expect exactly one `spike`, at the sample with v=2048 (timestamp 12), and `evt_ts`=12.
- Sinusoid-like input crossing V_TH every 10 samples, REFRACT=32. Expect spikes suppressed until 32 samples have elapsed and V < -1024 has been seen. Spike count matches the reference model.
- Hold `v_in` at +3000 for 100 samples after the first spike. Expect no further spike, `armed`=0 throughout.
- `evt_ready`=0 with 6 forced spikes, DEPTH=4. Expect 4 events retained in order and `overflow`=1. Then assert `evt_ready`: the 4 timestamps drain in order and `overflow` stays 1.
- FIFO full with a push and pop in the same cycle. Expect occupancy to stay at 4, the new timestamp queued last, and `overflow` unchanged.
- Assert `rst` mid-REFRACT with 2 queued events. Expect all outputs at reset values next cycle, the FIFO empty, and `ts` restarting at 0.
